// File: rtl/tsc_multicycle_core_if.sv
// Shared instruction/data memory port of the TSC multi-cycle core.
// The core is the master; transfers complete on any cycle with mem_req && mem_ready.
interface tsc_multicycle_core_if #(
  parameter int unsigned WORD_SIZE = 16
) ();
  logic                 mem_req;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/tsc_multicycle_core.sv
// Multi-cycle TSC CPU: IF/ID/EX/MEM/WB/HALT over a single req/ready memory port.
// Bus outputs are combinational from state so a zero-wait fetch costs exactly one cycle.
module tsc_multicycle_core #(
  parameter int unsigned          WORD_SIZE   = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC    = '0,
  parameter int unsigned          COUNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_cpu_n,
  input  logic                     cpu_enable,
  tsc_multicycle_core_if.master    bus,
  input  logic                     wwd_enable,
  input  logic [1:0]               register_selection,
  output logic [WORD_SIZE-1:0]     output_port,
  output logic                     wwd_valid,
  output logic                     halted,
  output logic [COUNT_WIDTH-1:0]   num_inst,
  output logic [7:0]               PC_below8bit
);

  typedef enum logic [2:0] {StIf, StId, StEx, StMem, StWb, StHalt} state_e;

  localparam logic [3:0] OpBne = 4'd0;
  localparam logic [3:0] OpBeq = 4'd1;
  localparam logic [3:0] OpBgz = 4'd2;
  localparam logic [3:0] OpBlz = 4'd3;
  localparam logic [3:0] OpAdi = 4'd4;
  localparam logic [3:0] OpOri = 4'd5;
  localparam logic [3:0] OpLhi = 4'd6;
  localparam logic [3:0] OpLwd = 4'd7;
  localparam logic [3:0] OpSwd = 4'd8;
  localparam logic [3:0] OpJmp = 4'd9;
  localparam logic [3:0] OpJal = 4'd10;
  localparam logic [3:0] OpR   = 4'd15;

  localparam logic [5:0] FnJpr = 6'd25;
  localparam logic [5:0] FnJrl = 6'd26;
  localparam logic [5:0] FnWwd = 6'd28;
  localparam logic [5:0] FnHlt = 6'd29;

  state_e                 state_q, state_d;
  logic [WORD_SIZE-1:0]   pc_q, pc_d;
  logic [15:0]            ir_q, ir_d;
  logic [WORD_SIZE-1:0]   a_q, a_d, b_q, b_d, npc_q, npc_d, res_q, res_d, wwd_q, wwd_d;
  logic [WORD_SIZE-1:0]   rf_q [4];
  logic [COUNT_WIDTH-1:0] num_inst_q;
  logic                   wwd_valid_q;

  logic                   rf_we;
  logic [1:0]             rf_waddr;
  logic [WORD_SIZE-1:0]   rf_wdata;
  logic                   retire, wwd_pulse;
  logic                   req, we;
  logic [WORD_SIZE-1:0]   addr, wdata;

  logic [3:0]             op;
  logic [1:0]             rs, rt, rd;
  logic [5:0]             func;
  logic [WORD_SIZE-1:0]   imm_sext, imm_zext, br_target, jmp_target, alu_r;
  logic                   br_taken;

  assign op         = ir_q[15:12];
  assign rs         = ir_q[11:10];
  assign rt         = ir_q[9:8];
  assign rd         = ir_q[7:6];
  assign func       = ir_q[5:0];
  assign imm_sext   = {{(WORD_SIZE - 8){ir_q[7]}}, ir_q[7:0]};
  assign imm_zext   = {{(WORD_SIZE - 8){1'b0}}, ir_q[7:0]};
  assign br_target  = npc_q + imm_sext;
  assign jmp_target = {pc_q[WORD_SIZE-1:12], ir_q[11:0]};

  always_comb begin
    alu_r = a_q + b_q;
    unique case (func[2:0])
      3'd0: alu_r = a_q + b_q;
      3'd1: alu_r = a_q - b_q;
      3'd2: alu_r = a_q & b_q;
      3'd3: alu_r = a_q | b_q;
      3'd4: alu_r = ~a_q;
      3'd5: alu_r = ~a_q + WORD_SIZE'(1);
      3'd6: alu_r = {a_q[WORD_SIZE-2:0], 1'b0};
      3'd7: alu_r = {a_q[WORD_SIZE-1], a_q[WORD_SIZE-1:1]};
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (op)
      OpBne:   br_taken = (a_q != b_q);
      OpBeq:   br_taken = (a_q == b_q);
      OpBgz:   br_taken = !a_q[WORD_SIZE-1] && (a_q != '0);
      OpBlz:   br_taken = a_q[WORD_SIZE-1];
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    npc_d     = npc_q;
    res_d     = res_q;
    wwd_d     = wwd_q;
    rf_we     = 1'b0;
    rf_waddr  = rd;
    rf_wdata  = res_q;
    retire    = 1'b0;
    wwd_pulse = 1'b0;
    req       = 1'b0;
    we        = 1'b0;
    addr      = pc_q;
    wdata     = '0;

    unique case (state_q)
      StIf: begin
        if (cpu_enable) begin
          req = 1'b1;
          if (bus.mem_ready) begin
            ir_d    = bus.mem_rdata[15:0];
            state_d = StId;
          end
        end
      end
      StId: begin
        a_d   = rf_q[rs];
        b_d   = rf_q[rt];
        npc_d = pc_q + WORD_SIZE'(1);
        if (op == OpR && func == FnHlt) begin
          retire  = 1'b1;
          state_d = StHalt;
        end else begin
          state_d = StEx;
        end
      end
      StEx: begin
        // Control-flow and undefined instructions retire here; the rest move on.
        state_d = StIf;
        retire  = 1'b1;
        pc_d    = npc_q;
        case (op)
          OpBne, OpBeq, OpBgz, OpBlz: pc_d = br_taken ? br_target : npc_q;
          OpAdi: begin res_d = a_q + imm_sext;  retire = 1'b0; state_d = StWb; end
          OpOri: begin res_d = a_q | imm_zext;  retire = 1'b0; state_d = StWb; end
          OpLhi: begin res_d = imm_zext << 8;   retire = 1'b0; state_d = StWb; end
          OpLwd, OpSwd: begin retire = 1'b0; state_d = StMem; end
          OpJmp: pc_d = jmp_target;
          OpJal: begin
            pc_d     = jmp_target;
            rf_we    = 1'b1;
            rf_waddr = 2'd2;
            rf_wdata = npc_q;
          end
          OpR: begin
            if (func[5:3] == 3'b000) begin
              res_d   = alu_r;
              retire  = 1'b0;
              state_d = StWb;
            end else begin
              case (func)
                FnJpr: pc_d = a_q;
                FnJrl: begin
                  pc_d     = a_q;
                  rf_we    = 1'b1;
                  rf_waddr = 2'd2;
                  rf_wdata = npc_q;
                end
                FnWwd: begin
                  wwd_d     = a_q;
                  wwd_pulse = 1'b1;
                end
                default: pc_d = npc_q;
              endcase
            end
          end
          default: pc_d = npc_q;
        endcase
      end
      StMem: begin
        req  = 1'b1;
        addr = a_q + imm_sext;
        if (op == OpSwd) begin
          we    = 1'b1;
          wdata = b_q;
        end
        if (bus.mem_ready) begin
          if (op == OpSwd) begin
            pc_d    = npc_q;
            retire  = 1'b1;
            state_d = StIf;
          end else begin
            res_d   = bus.mem_rdata;
            state_d = StWb;
          end
        end
      end
      StWb: begin
        rf_we    = 1'b1;
        rf_waddr = (op == OpR) ? rd : rt;
        rf_wdata = res_q;
        pc_d     = npc_q;
        retire   = 1'b1;
        state_d  = StIf;
      end
      StHalt: state_d = StHalt;
      default: state_d = StIf;
    endcase
  end

  always_ff @(posedge clk or negedge reset_cpu_n) begin
    if (!reset_cpu_n) begin
      state_q     <= StIf;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      npc_q       <= '0;
      res_q       <= '0;
      wwd_q       <= '0;
      num_inst_q  <= '0;
      wwd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      npc_q       <= npc_d;
      res_q       <= res_d;
      wwd_q       <= wwd_d;
      wwd_valid_q <= wwd_pulse;
      if (retire) num_inst_q <= num_inst_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_cpu_n) begin
    if (!reset_cpu_n) begin
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Gating with the reset input drops a pending request the instant reset asserts.
  assign bus.mem_req   = req & reset_cpu_n;
  assign bus.mem_we    = bus.mem_req & we;
  assign bus.mem_addr  = bus.mem_req ? addr : '0;
  assign bus.mem_wdata = bus.mem_req ? wdata : '0;

  assign output_port  = wwd_enable ? wwd_q : rf_q[register_selection];
  assign wwd_valid    = wwd_valid_q;
  assign halted       = (state_q == StHalt);
  assign num_inst     = num_inst_q;
  assign PC_below8bit = pc_q[7:0];

endmodule

// File: tb/tb_tsc_multicycle_core.sv
// Directed bench for tsc_multicycle_core: small programs in a wait-state-capable memory model.
module tb_tsc_multicycle_core;
  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          reset_cpu_n = 1'b0;
  logic          cpu_enable = 1'b0;
  logic          wwd_enable = 1'b1;
  logic [1:0]    register_selection = 2'd0;
  logic [W-1:0]  output_port;
  logic          wwd_valid;
  logic          halted;
  logic [15:0]   num_inst;
  logic [7:0]    pc_lo;

  tsc_multicycle_core_if #(.WORD_SIZE(W)) bus ();

  tsc_multicycle_core #(.WORD_SIZE(W), .RESET_PC(16'h0000), .COUNT_WIDTH(16)) dut (
    .clk                (clk),
    .reset_cpu_n        (reset_cpu_n),
    .cpu_enable         (cpu_enable),
    .bus                (bus),
    .wwd_enable         (wwd_enable),
    .register_selection (register_selection),
    .output_port        (output_port),
    .wwd_valid          (wwd_valid),
    .halted             (halted),
    .num_inst           (num_inst),
    .PC_below8bit       (pc_lo)
  );

  initial forever #5 clk = ~clk;

  logic [W-1:0] mem [64];
  int checks = 0;
  int errors = 0;
  int wait_states = 0;
  int cyc_total = 0;
  int base = 0;
  int wait_cnt = 0;
  int req_cycles = 0, we_cycles = 0, write_count = 0, addr_changes = 0;
  logic [W-1:0] held_addr, held_wdata, last_waddr, last_wdata;
  logic         held_we;
  int wwd_cnt = 0, wwd_cyc = 0;
  logic [W-1:0] wwd_val;
  logic [15:0]  wwd_num;

  initial forever begin
    @(posedge clk);
    cyc_total++;
  end

  // Memory responder: decides ready on the falling edge so the core sees it on the next rise.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        req_cycles++;
        if (bus.mem_we === 1'b1) we_cycles++;
        if (wait_cnt == 0) begin
          held_addr  = bus.mem_addr;
          held_we    = bus.mem_we;
          held_wdata = bus.mem_wdata;
        end else if (bus.mem_addr !== held_addr || bus.mem_we !== held_we ||
                     bus.mem_wdata !== held_wdata) begin
          addr_changes++;
        end
        if (wait_cnt >= wait_states) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem[bus.mem_addr[5:0]];
          if (bus.mem_we === 1'b1) begin
            mem[bus.mem_addr[5:0]] = bus.mem_wdata;
            write_count++;
            last_waddr = bus.mem_addr;
            last_wdata = bus.mem_wdata;
          end
          wait_cnt = 0;
        end else begin
          bus.mem_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.mem_ready = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (wwd_valid === 1'b1) begin
      wwd_cnt++;
      wwd_cyc = cyc_total - base;
      wwd_val = output_port;
      wwd_num = num_inst;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = '0;
  endtask

  task automatic load_prog1();
    clear_mem();
    mem[0] = 16'h6101;  // LHI $1,1
    mem[1] = 16'h4604;  // ADI $2,$1,4
    mem[2] = 16'hF81C;  // WWD $2
    mem[3] = 16'hF01D;  // HLT
  endtask

  task automatic reset_core(input int ws, input bit en);
    reset_cpu_n = 1'b0;
    cpu_enable  = 1'b0;
    wait_states = ws;
    repeat (2) @(posedge clk);
    #2;
    reset_cpu_n = 1'b1;
    cpu_enable  = en;
    base        = cyc_total;
  endtask

  task automatic wait_wwd(input int snap, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (wwd_cnt > snap) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_halt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (halted === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_num(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (num_inst == 16'(n)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset_cpu_n = 1'b0;
    cpu_enable  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0000", bus.mem_addr); end
    checks++; if (wwd_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_flags: got wwd_valid=%b halted=%b want 0 0", wwd_valid, halted); end
    checks++; if (num_inst !== 16'h0 || pc_lo !== 8'h00) begin errors++; $display("FAIL reset_count_pc: got num=%h pc=%h want 0 0", num_inst, pc_lo); end
    checks++; if (output_port !== 16'h0) begin errors++; $display("FAIL reset_output: got %h want 0000", output_port); end
  endtask

  task automatic test_zero_wait();
    bit ok;
    int snap;
    load_prog1();
    snap = wwd_cnt;
    reset_core(0, 1'b1);
    wait_wwd(snap, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zw_wwd_seen: got none want pulse"); end
    checks++; if (wwd_val !== 16'h0104) begin errors++; $display("FAIL zw_wwd_value: got %h want 0104", wwd_val); end
    checks++; if (wwd_cyc != 11) begin errors++; $display("FAIL zw_wwd_cycle: got %0d want 11", wwd_cyc); end
    checks++; if (wwd_num !== 16'd3) begin errors++; $display("FAIL zw_num_at_wwd: got %0d want 3", wwd_num); end
    wait_halt(ok);
    checks++; if (!ok || num_inst !== 16'd4) begin errors++; $display("FAIL zw_halt: got halted=%b num=%0d want 1 4", halted, num_inst); end
    checks++; if (wwd_cnt != snap + 1) begin errors++; $display("FAIL zw_wwd_pulses: got %0d want 1", wwd_cnt - snap); end
  endtask

  task automatic test_wait_states();
    bit ok;
    int snap, chg;
    load_prog1();
    snap = wwd_cnt;
    chg  = addr_changes;
    reset_core(2, 1'b1);
    wait_wwd(snap, ok);
    checks++; if (!ok || wwd_val !== 16'h0104) begin errors++; $display("FAIL ws_wwd_value: got %h want 0104", wwd_val); end
    checks++; if (wwd_cyc != 17) begin errors++; $display("FAIL ws_wwd_cycle: got %0d want 17", wwd_cyc); end
    wait_halt(ok);
    checks++; if (!ok || num_inst !== 16'd4) begin errors++; $display("FAIL ws_halt: got halted=%b num=%0d want 1 4", halted, num_inst); end
    checks++; if (addr_changes != chg) begin errors++; $display("FAIL ws_bus_stable: got %0d changes want 0", addr_changes - chg); end
  endtask

  task automatic test_load_store();
    bit ok;
    int we0, wr0;
    clear_mem();
    mem[0] = 16'h6101;  // LHI $1,1
    mem[1] = 16'h8105;  // SWD $1 -> [$0+5]
    mem[2] = 16'h7305;  // LWD $3 <- [$0+5]
    mem[3] = 16'hF01D;  // HLT
    we0 = we_cycles;
    wr0 = write_count;
    reset_core(0, 1'b1);
    wait_halt(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ls_halt: got halted=%b want 1", halted); end
    checks++; if (we_cycles - we0 != 1 || write_count - wr0 != 1) begin errors++; $display("FAIL ls_we_once: got %0d we cycles want 1", we_cycles - we0); end
    checks++; if (last_waddr !== 16'h0005 || last_wdata !== 16'h0100) begin errors++; $display("FAIL ls_write: got addr=%h data=%h want 0005 0100", last_waddr, last_wdata); end
    wwd_enable = 1'b0;
    register_selection = 2'd3;
    #1;
    checks++; if (output_port !== 16'h0100) begin errors++; $display("FAIL ls_reg3: got %h want 0100", output_port); end
    wwd_enable = 1'b1;
  endtask

  task automatic test_branch_jump();
    bit ok;
    int snap;
    clear_mem();
    mem[0]     = 16'h4102;  // ADI $1,$0,2
    mem[1]     = 16'h45FF;  // ADI $1,$1,-1
    mem[2]     = 16'h04FE;  // BNE $1,$0,-2
    mem[3]     = 16'hF41C;  // WWD $1
    mem[4]     = 16'h9010;  // JMP 0x010
    mem[6'h10] = 16'hA015;  // JAL 0x015
    mem[6'h11] = 16'hF81C;  // WWD $2
    mem[6'h12] = 16'hF01D;  // HLT
    mem[6'h15] = 16'hF819;  // JPR $2
    snap = wwd_cnt;
    reset_core(0, 1'b1);
    wait_wwd(snap, ok);
    checks++; if (!ok || wwd_val !== 16'h0000 || wwd_num !== 16'd6) begin errors++; $display("FAIL br_loop: got val=%h num=%0d want 0000 6", wwd_val, wwd_num); end
    checks++; if (wwd_cyc != 21) begin errors++; $display("FAIL br_cycles: got %0d want 21", wwd_cyc); end
    wait_num(8, ok);
    checks++; if (!ok || pc_lo !== 8'h15) begin errors++; $display("FAIL jal_pc: got %h want 15", pc_lo); end
    wait_num(9, ok);
    checks++; if (!ok || pc_lo !== 8'h11) begin errors++; $display("FAIL jpr_pc: got %h want 11", pc_lo); end
    wait_wwd(snap + 1, ok);
    checks++; if (!ok || wwd_val !== 16'h0011) begin errors++; $display("FAIL jal_link_wwd: got %h want 0011", wwd_val); end
    wait_halt(ok);
    checks++; if (!ok || num_inst !== 16'd11) begin errors++; $display("FAIL br_num: got %0d want 11", num_inst); end
  endtask

  task automatic test_alu_undefined();
    bit ok;
    int we0;
    clear_mem();
    mem[0] = 16'h617F;  // LHI $1,0x7F
    mem[1] = 16'h55FF;  // ORI $1,$1,0xFF
    mem[2] = 16'h4201;  // ADI $2,$0,1
    mem[3] = 16'hF6C0;  // ADD $3,$1,$2
    mem[4] = 16'hB6C0;  // undefined opcode
    mem[5] = 16'hF6C8;  // undefined func
    mem[6] = 16'hFC1C;  // WWD $3
    mem[7] = 16'hF01D;  // HLT
    we0 = we_cycles;
    reset_core(0, 1'b1);
    wait_halt(ok);
    checks++; if (!ok || num_inst !== 16'd8) begin errors++; $display("FAIL alu_num: got %0d want 8", num_inst); end
    checks++; if (wwd_val !== 16'h8000) begin errors++; $display("FAIL alu_add_wrap: got %h want 8000", wwd_val); end
    checks++; if (we_cycles != we0) begin errors++; $display("FAIL undef_no_write: got %0d writes want 0", we_cycles - we0); end
    wwd_enable = 1'b0;
    register_selection = 2'd0; #1;
    checks++; if (output_port !== 16'h0000) begin errors++; $display("FAIL alu_r0: got %h want 0000", output_port); end
    register_selection = 2'd1; #1;
    checks++; if (output_port !== 16'h7FFF) begin errors++; $display("FAIL alu_r1: got %h want 7fff", output_port); end
    register_selection = 2'd2; #1;
    checks++; if (output_port !== 16'h0001) begin errors++; $display("FAIL alu_r2: got %h want 0001", output_port); end
    register_selection = 2'd3; #1;
    checks++; if (output_port !== 16'h8000) begin errors++; $display("FAIL alu_r3: got %h want 8000", output_port); end
    wwd_enable = 1'b1;
  endtask

  task automatic test_halt_freeze();
    int rq0;
    logic [15:0] n0;
    rq0 = req_cycles;
    n0  = num_inst;
    repeat (20) @(negedge clk);
    #1;
    checks++; if (req_cycles != rq0) begin errors++; $display("FAIL halt_no_req: got %0d req cycles want 0", req_cycles - rq0); end
    checks++; if (num_inst !== n0 || halted !== 1'b1) begin errors++; $display("FAIL halt_freeze: got num=%0d halted=%b want %0d 1", num_inst, halted, n0); end
  endtask

  task automatic test_cpu_enable();
    bit ok;
    int rq0, snap;
    load_prog1();
    rq0  = req_cycles;
    snap = wwd_cnt;
    reset_core(0, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    checks++; if (req_cycles != rq0 || num_inst !== 16'd0) begin errors++; $display("FAIL en_hold: got req=%0d num=%0d want 0 0", req_cycles - rq0, num_inst); end
    cpu_enable = 1'b1;
    wait_wwd(snap, ok);
    checks++; if (!ok || wwd_val !== 16'h0104) begin errors++; $display("FAIL en_resume: got %h want 0104", wwd_val); end
  endtask

  task automatic test_reset_mid_fetch();
    bit ok;
    int snap;
    load_prog1();
    reset_core(3, 1'b1);
    wait_num(2, ok);
    checks++; if (!ok || bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0002) begin errors++; $display("FAIL rst_pending: got req=%b addr=%h want 1 0002", bus.mem_req, bus.mem_addr); end
    reset_cpu_n = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 16'h0) begin errors++; $display("FAIL rst_bus_clear: got req=%b addr=%h want 0 0000", bus.mem_req, bus.mem_addr); end
    checks++; if (num_inst !== 16'd0 || pc_lo !== 8'h00 || halted !== 1'b0) begin errors++; $display("FAIL rst_state: got num=%0d pc=%h halted=%b want 0 00 0", num_inst, pc_lo, halted); end
    wwd_enable = 1'b0;
    register_selection = 2'd1; #1;
    checks++; if (output_port !== 16'h0000) begin errors++; $display("FAIL rst_regs: got %h want 0000", output_port); end
    wwd_enable = 1'b1;
    snap = wwd_cnt;
    reset_core(0, 1'b1);
    wait_wwd(snap, ok);
    checks++; if (!ok || wwd_val !== 16'h0104 || wwd_cyc != 11) begin errors++; $display("FAIL rst_restart: got val=%h cyc=%0d want 0104 11", wwd_val, wwd_cyc); end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_load_store();
    test_branch_jump();
    test_alu_undefined();
    test_halt_freeze();
    test_cpu_enable();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tsc_multicycle_core.md
# tsc_multicycle_core

Parametrised multi-cycle successor to the single-cycle TSC CPU. It executes the full TSC ISA: ALU, immediate, load/store, branch, jump, link, WWD and HLT. Instructions and data come from a single external memory over a req/ready handshake, so the core tolerates wait states. It sits between the board I/O logic (output_port, PC LEDs) and a shared instruction/data memory.

## Interface
- WORD_SIZE, 16: datapath, register, PC and memory word width; must be >= 16. Instruction is mem_rdata[15:0].
- RESET_PC, 0: PC value loaded at reset.
- COUNT_WIDTH, 16: width of num_inst.
- clk  in  1  single clock, all state on rising edge.
- reset_cpu_n  in  1  asynchronous, active-low reset.
- cpu_enable  in  1  when 0, no new instruction fetch is issued. An in-flight instruction always completes.
- mem_req  out  1  memory request. Held until accepted.
- mem_we  out  1  1 = write (SWD), 0 = read.
- mem_addr  out  WORD_SIZE  word address.
- mem_wdata  out  WORD_SIZE  store data.
- mem_rdata  in  WORD_SIZE  read data. Valid when mem_ready=1.
- mem_ready  in  1  transaction completes in any cycle with mem_req=1 and mem_ready=1.
- wwd_enable  in  1  1: output_port shows the last WWD value. 0: output_port shows register[register_selection].
- register_selection  in  2  register shown when wwd_enable=0.
- output_port  out  WORD_SIZE  display value.
- wwd_valid  out  1  one-cycle pulse when a WWD completes.
- halted  out  1  high after HLT until reset.
- num_inst  out  COUNT_WIDTH  retired-instruction count.
- PC_below8bit  out  8  PC[7:0].

## Operation
- Registers: 4 × WORD_SIZE, addressed by rs=[11:10], rt=[9:8], rd=[7:6]. No hardwired zero.
- FSM states: IF, ID, EX, MEM, WB, HALT.
  - IF: when cpu_enable=1, assert mem_req with mem_we=0 and mem_addr=PC. On mem_ready, latch IR and go to ID.
  - ID: read rs/rt into A/B; NPC=PC+1. HLT goes to HALT. All others go to EX.
  - EX: compute the ALU result, branch condition or target.
    - Branch, jump, JPR, WWD and undefined opcode: update PC and retire, then IF.
    - LWD/SWD: go to MEM.
    - All others: go to WB.
  - MEM: assert mem_req with addr=A+sext(imm); for SWD, mem_we=1 and wdata=B. On ready: LWD goes to WB; SWD retires and goes to IF.
  - WB: write the destination register, PC=NPC, retire, go to IF.
  - HALT: terminal until reset; no memory requests.
- Opcode 15 funcs:
  - 0–7: ADD, SUB, AND, ORR, NOT, TCP, SHL, SHR. Destination rd. SHR is arithmetic.
  - 25: JPR (PC=A). 26: JRL (PC=A, $2=NPC).
  - 28: WWD (latch A, pulse wwd_valid). 29: HLT.
- Other opcodes:
  - ADI=4, ORI=5 (zero-extended), LHI=6: destination rt.
  - LWD=7, SWD=8.
  - BNE=0, BEQ=1 compare A and B. BGZ=2, BLZ=3 compare A, signed, against 0. Taken target = NPC+sext(imm).
  - JMP=9: PC={PC[WORD_SIZE-1:12], IR[11:0]}. JAL=10: same target, $2=NPC.
- Arithmetic: wraps mod 2^WORD_SIZE. sext(imm) extends imm[7] to WORD_SIZE. LHI = imm<<8, upper bits zero.
- Undefined opcode or func: no register or memory write; PC=NPC; counts as retired.
- Reset values: PC=RESET_PC, registers=0, IR=0, state=IF, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, output_port latch=0, wwd_valid=0, halted=0, num_inst=0.

## Timing
- Cycles per instruction, with zero wait states (mem_ready high in the cycle mem_req rises):
  - Branch, jump, JPR, JRL, WWD: 3 (IF, ID, EX).
  - ALU and immediate ops, SWD: 4.
  - LWD: 5.
  - HLT: 2, then HALT.
- Each wait state adds one cycle in IF or MEM.
- While mem_req=1 and mem_ready=0: mem_addr, mem_we and mem_wdata hold stable. mem_req drops the cycle after acceptance.
- num_inst increments, and wwd_valid pulses, on the clock edge that retires the instruction. HLT is counted on entry to HALT.
- Register write in WB is visible to the next instruction's ID, so there is no hazard.
- cpu_enable=0 in IF holds the FSM in IF with mem_req=0. Deasserting cpu_enable mid-instruction does not stall it.
- Reset asserted mid-transaction: mem_req drops combinationally-immediately via the async clear, and the transaction is abandoned.
- output_port is combinational from wwd_enable, the WWD latch and the register file.

## Test plan
- Reset, then LHI $1,1 / ADI $2,$1,+4 / WWD $2, zero-wait memory -> WWD shows 0x0104. wwd_valid pulses at cycle 11. num_inst=3.
- Same program with mem_ready delayed 2 cycles on every request -> identical results. mem_addr stable during waits. Retire at cycle 17.
- SWD $1→addr 5, then LWD $3←addr 5 -> mem_we=1 exactly once, addr=5, wdata=0x0100. Afterwards register[3]=0x0100.
- BNE taken and not taken with imm=-2. JAL 0x015 from PC=0x0010 -> PC=0x0015 and $2=0x0011. JPR $2 -> PC=0x0011.
- ADD 0x7FFF+0x0001 -> 0x8000 (wrap, no trap). Undefined opcode 0xB -> no state change except PC+1 and num_inst+1.
- HLT -> halted=1, mem_req stays 0 and num_inst freezes. reset_cpu_n pulsed during a pending fetch -> all outputs at reset values, restart from RESET_PC.
